mmio_fifo_bank: RTL and testbench
=================================

MMIO_FIFO_BANK -- requirements
Module: mmio_fifo_bank

Interface
REQ-001 SHALL have parameter NUM_CH, default 4, number of independent FIFO channels (1..8).
REQ-002 SHALL have parameter DEPTH, default 16, entries per channel (power of 2, 2..1024).
REQ-003 SHALL have parameter WIDTH, default 64, stored data bits per entry (1..64).
REQ-004 SHALL have port clk  input  1  sole clock; all logic on rising edge.
REQ-005 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-006 SHALL have port mmio_wr_valid  input  1  MMIO write strobe.
REQ-007 SHALL have port mmio_rd_valid  input  1  MMIO read strobe.
REQ-008 SHALL have port mmio_addr  input  16  dword address of the request.
REQ-009 SHALL have port mmio_tid  input  9  read transaction ID.
REQ-010 SHALL have port mmio_wdata  input  64  write data.
REQ-011 SHALL have port rd_resp_valid  output  1  read response strobe.
REQ-012 SHALL have port rd_resp_tid  output  9  echoed TID.
REQ-013 SHALL have port rd_resp_data  output  64  read response data.

Function
REQ-014 Address map, ch = 0..NUM_CH-1: DATA(ch)=0x0020+2*ch, STATUS(ch)=0x0040+2*ch, CTRL=0x0060, PEEK(ch)=0x0080+2*ch.
REQ-015 Write to DATA(ch) SHALL push mmio_wdata[WIDTH-1:0] when not full; when full, data dropped, sticky OVF(ch) set.
REQ-016 Read of DATA(ch) SHALL return head entry zero-extended to 64 bits and pop it; when empty, return 0, no pop, sticky UNF(ch) set.
REQ-017 STATUS(ch) read SHALL return {44'b0, UNF[19], OVF[18], full[17], empty[16], count[15:0]}; no side effects.
REQ-018 CTRL write: bit ch of mmio_wdata[7:0] SHALL empty channel ch and clear OVF(ch)/UNF(ch) next cycle; bits >= NUM_CH ignored; CTRL reads return 0.
REQ-019 Every read SHALL produce rd_resp_valid high for exactly one cycle, cycle after mmio_rd_valid, with rd_resp_tid = mmio_tid; unmapped or out-of-range addresses return 0.
REQ-020 rd_resp_valid SHALL be low in every cycle without a read one cycle earlier; back-to-back reads give back-to-back responses.
REQ-021 count SHALL range 0..DEPTH, width clog2(DEPTH)+1; read/write pointers wrap modulo DEPTH.
REQ-022 Simultaneous wr_valid and rd_valid: read SHALL see pre-write state; on same channel with full FIFO push succeeds if pop occurs same cycle; with empty FIFO read returns 0 and push succeeds.
REQ-023 CTRL clear of ch coincident with a push to ch in the same cycle: clear SHALL win (channel ends empty).
REQ-024 Channels SHALL be fully independent; activity on one never alters another's state.

Reset
REQ-025 On rst all channels SHALL be empty, pointers 0, OVF/UNF 0, rd_resp_valid 0, rd_resp_tid 0, rd_resp_data 0.
REQ-026 rst SHALL override any request in the same cycle; a read issued the cycle before rst asserts SHALL not produce a response.

Configuration
REQ-027 Macro MMIO_FIFO_PEEK_EN defined: PEEK(ch) read SHALL return head entry (0 if empty) without pop or flag change.
REQ-028 Macro MMIO_FIFO_PEEK_EN undefined: PEEK addresses SHALL behave as unmapped (return 0), no peek logic synthesised.

Structure
REQ-029 Package mmio_fifo_pkg SHALL hold address constants (DATA/STATUS/CTRL/PEEK bases, stride 2) and STATUS bit positions.
REQ-030 One sub-module mmio_fifo_ch SHALL implement a single synchronous FIFO (push, pop, clear, head, count, full, empty), instantiated NUM_CH times via generate.

Verification
REQ-031 Write 0xA5 to 0x0020 then read 0x0020 tid 0x11 -> response next cycle, data 0xA5, tid 0x11; then STATUS(0) = 0x10000 (empty).
REQ-032 DEPTH=16: 17 writes 1..17 to 0x0022 -> STATUS(1) count 16, full 1, OVF 1; 16 reads return 1..16 in order.
REQ-033 Read 0x0024 on empty ch2 -> data 0, UNF(2) set; write 0x04 to 0x0060 -> STATUS(2) = 0x10000.
REQ-034 Write 0x1 to ch0 and ch3, clear ch0 via CTRL 0x01 -> ch3 still count 1; read 0x0026 returns 0x1.
REQ-035 With MMIO_FIFO_PEEK_EN, write 0x55 to ch0, read 0x0080 twice -> both 0x55, count stays 1; without macro -> both 0.
REQ-036 Assert rst with 5 entries in ch1 and read pending -> no response, STATUS(1) = 0x10000 after reset.

Source files
------------

// File: rtl/mmio_fifo_pkg.sv
// Address map, STATUS word layout and decode helpers shared by the MMIO FIFO bank.
// Addresses are dword addresses; per-channel registers sit at a stride of 2.
package mmio_fifo_pkg;

    localparam logic [15:0] DATA_BASE   = 16'h0020;
    localparam logic [15:0] STATUS_BASE = 16'h0040;
    localparam logic [15:0] CTRL_ADDR   = 16'h0060;
    localparam logic [15:0] PEEK_BASE   = 16'h0080;
    localparam int unsigned CH_STRIDE   = 2;

    localparam int unsigned ST_EMPTY_BIT = 16;
    localparam int unsigned ST_FULL_BIT  = 17;
    localparam int unsigned ST_OVF_BIT   = 18;
    localparam int unsigned ST_UNF_BIT   = 19;

    typedef enum logic [1:0] {
        RegData,
        RegStatus,
        RegCtrl,
        RegPeek
    } reg_kind_e;

    function automatic logic [15:0] reg_addr(input reg_kind_e kind, input int unsigned ch);
        logic [15:0] off;
        logic [15:0] addr;
        off = 16'(CH_STRIDE * ch);
        unique case (kind)
            RegData:   addr = DATA_BASE + off;
            RegStatus: addr = STATUS_BASE + off;
            RegCtrl:   addr = CTRL_ADDR;
            RegPeek:   addr = PEEK_BASE + off;
        endcase
        return addr;
    endfunction

    function automatic logic [63:0] status_word(
        input logic        unf,
        input logic        ovf,
        input logic        full,
        input logic        empty,
        input logic [15:0] count
    );
        logic [63:0] word;
        word               = '0;
        word[15:0]         = count;
        word[ST_EMPTY_BIT] = empty;
        word[ST_FULL_BIT]  = full;
        word[ST_OVF_BIT]   = ovf;
        word[ST_UNF_BIT]   = unf;
        return word;
    endfunction

endpackage

// File: rtl/mmio_fifo_ch.sv
// Single synchronous FIFO channel with sticky overflow/underflow flags.
// Clear and reset both win over any push or pop in the same cycle.
module mmio_fifo_ch #(
    parameter int unsigned DEPTH = 16,
    parameter int unsigned WIDTH = 64
) (
    input  logic                     i_clk,
    input  logic                     i_rst,
    input  logic                     i_push,
    input  logic                     i_pop,
    input  logic                     i_clr,
    input  logic [WIDTH-1:0]         i_wdata,
    output logic [WIDTH-1:0]         o_head,
    output logic [$clog2(DEPTH):0]   o_count,
    output logic                     o_full,
    output logic                     o_empty,
    output logic                     o_ovf,
    output logic                     o_unf
);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [CW-1:0]    r_count;
    logic             r_ovf;
    logic             r_unf;

    logic w_full;
    logic w_empty;
    logic w_pop_ok;
    logic w_push_ok;

    assign w_empty   = (r_count == '0);
    assign w_full    = (r_count == CW'(DEPTH));
    assign w_pop_ok  = i_pop & ~w_empty;
    // A full FIFO still accepts a push when the head leaves in the same cycle.
    assign w_push_ok = i_push & (~w_full | w_pop_ok);

    always_ff @(posedge i_clk) begin
        if (i_rst || i_clr) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_ovf    <= 1'b0;
            r_unf    <= 1'b0;
        end else begin
            if (w_push_ok) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_pop_ok) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            r_count <= r_count + CW'(w_push_ok) - CW'(w_pop_ok);
            if (i_push && !w_push_ok) begin
                r_ovf <= 1'b1;
            end
            if (i_pop && w_empty) begin
                r_unf <= 1'b1;
            end
        end
    end

    // Storage needs no reset; validity is tracked by the pointers and count.
    always_ff @(posedge i_clk) begin
        if (w_push_ok) begin
            r_mem[r_wr_ptr] <= i_wdata;
        end
    end

    assign o_head  = r_mem[r_rd_ptr];
    assign o_count = r_count;
    assign o_full  = w_full;
    assign o_empty = w_empty;
    assign o_ovf   = r_ovf;
    assign o_unf   = r_unf;

endmodule

// File: rtl/mmio_fifo_bank.sv
// Bank of NUM_CH independent FIFOs behind a dword-addressed MMIO port with 1-cycle read responses.
// Define MMIO_FIFO_PEEK_EN to enable the non-destructive PEEK window; otherwise it reads as unmapped.
module mmio_fifo_bank
    import mmio_fifo_pkg::*;
#(
    parameter int unsigned NUM_CH = 4,
    parameter int unsigned DEPTH  = 16,
    parameter int unsigned WIDTH  = 64
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        mmio_wr_valid,
    input  logic        mmio_rd_valid,
    input  logic [15:0] mmio_addr,
    input  logic [8:0]  mmio_tid,
    input  logic [63:0] mmio_wdata,
    output logic        rd_resp_valid,
    output logic [8:0]  rd_resp_tid,
    output logic [63:0] rd_resp_data
);
    localparam int unsigned CW = $clog2(DEPTH) + 1;

    logic [NUM_CH-1:0] w_data_hit;
    logic [NUM_CH-1:0] w_stat_hit;
    logic [NUM_CH-1:0] w_push;
    logic [NUM_CH-1:0] w_pop;
    logic [NUM_CH-1:0] w_clr;
    logic [NUM_CH-1:0] w_full;
    logic [NUM_CH-1:0] w_empty;
    logic [NUM_CH-1:0] w_ovf;
    logic [NUM_CH-1:0] w_unf;
    logic [WIDTH-1:0]  w_head  [NUM_CH];
    logic [CW-1:0]     w_count [NUM_CH];
    logic              w_ctrl_hit;
    logic [63:0]       w_rdata;
`ifdef MMIO_FIFO_PEEK_EN
    logic [NUM_CH-1:0] w_peek_hit;
`endif

    logic        r_resp_valid;
    logic [8:0]  r_resp_tid;
    logic [63:0] r_resp_data;

    assign w_ctrl_hit = (mmio_addr == reg_addr(RegCtrl, 0));

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        assign w_data_hit[g] = (mmio_addr == reg_addr(RegData, g));
        assign w_stat_hit[g] = (mmio_addr == reg_addr(RegStatus, g));
`ifdef MMIO_FIFO_PEEK_EN
        assign w_peek_hit[g] = (mmio_addr == reg_addr(RegPeek, g));
`endif
        assign w_push[g] = mmio_wr_valid & w_data_hit[g];
        assign w_pop[g]  = mmio_rd_valid & w_data_hit[g];
        assign w_clr[g]  = mmio_wr_valid & w_ctrl_hit & mmio_wdata[g];

        mmio_fifo_ch #(
            .DEPTH (DEPTH),
            .WIDTH (WIDTH)
        ) u_ch (
            .i_clk   (clk),
            .i_rst   (rst),
            .i_push  (w_push[g]),
            .i_pop   (w_pop[g]),
            .i_clr   (w_clr[g]),
            .i_wdata (mmio_wdata[WIDTH-1:0]),
            .o_head  (w_head[g]),
            .o_count (w_count[g]),
            .o_full  (w_full[g]),
            .o_empty (w_empty[g]),
            .o_ovf   (w_ovf[g]),
            .o_unf   (w_unf[g])
        );
    end

    // Read data reflects channel state before this cycle's push/pop/clear.
    always_comb begin
        w_rdata = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (w_data_hit[i] && !w_empty[i]) begin
                w_rdata = 64'(w_head[i]);
            end
            if (w_stat_hit[i]) begin
                w_rdata = status_word(w_unf[i], w_ovf[i], w_full[i], w_empty[i],
                                      16'(w_count[i]));
            end
`ifdef MMIO_FIFO_PEEK_EN
            if (w_peek_hit[i] && !w_empty[i]) begin
                w_rdata = 64'(w_head[i]);
            end
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_resp_valid <= 1'b0;
            r_resp_tid   <= '0;
            r_resp_data  <= '0;
        end else begin
            r_resp_valid <= mmio_rd_valid;
            if (mmio_rd_valid) begin
                r_resp_tid  <= mmio_tid;
                r_resp_data <= w_rdata;
            end
        end
    end

    // Reset suppresses a response already in flight from the previous cycle.
    assign rd_resp_valid = r_resp_valid & ~rst;
    assign rd_resp_tid   = r_resp_tid;
    assign rd_resp_data  = r_resp_data;

endmodule

// File: tb/tb_mmio_fifo_bank.sv
// Randomised bench for mmio_fifo_bank against a queue-based reference model,
// plus directed sequences with literal expectations.
module tb_mmio_fifo_bank;
    localparam int NCH = 4;
    localparam int DEP = 16;
    localparam int WID = 64;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        wr = 1'b0;
    logic        rd = 1'b0;
    logic [15:0] addr = '0;
    logic [8:0]  tid = '0;
    logic [63:0] wdata = '0;
    logic        resp_valid;
    logic [8:0]  resp_tid;
    logic [63:0] resp_data;

    always #5 clk = ~clk;

    mmio_fifo_bank #(
        .NUM_CH (NCH),
        .DEPTH  (DEP),
        .WIDTH  (WID)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .mmio_wr_valid (wr),
        .mmio_rd_valid (rd),
        .mmio_addr     (addr),
        .mmio_tid      (tid),
        .mmio_wdata    (wdata),
        .rd_resp_valid (resp_valid),
        .rd_resp_tid   (resp_tid),
        .rd_resp_data  (resp_data)
    );

    int n_cmp = 0;
    int n_bad = 0;

    logic [63:0] mq [NCH][$];
    logic        m_ovf [NCH];
    logic        m_unf [NCH];
    logic        exp_valid = 1'b0;
    logic [8:0]  exp_tid = '0;
    logic [63:0] exp_data = '0;
    logic        chk_en = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, req, $time);
        end
    endtask

    function automatic int chan_of(input logic [15:0] a, input logic [15:0] base);
        int d;
        d = int'(a) - int'(base);
        if (d >= 0 && d < 2 * NCH && (d % 2) == 0) return d / 2;
        return -1;
    endfunction

    function automatic logic [63:0] model_rd(input logic [15:0] a);
        int c;
        c = chan_of(a, 16'h0020);
        if (c >= 0) return (mq[c].size() > 0) ? mq[c][0] : 64'h0;
        c = chan_of(a, 16'h0040);
        if (c >= 0)
            return {44'h0, m_unf[c], m_ovf[c], mq[c].size() == DEP, mq[c].size() == 0,
                    16'(mq[c].size())};
`ifdef MMIO_FIFO_PEEK_EN
        c = chan_of(a, 16'h0080);
        if (c >= 0) return (mq[c].size() > 0) ? mq[c][0] : 64'h0;
`endif
        return 64'h0;
    endfunction

    // Drive one cycle, advance the model, and publish the response expected after the edge.
    task automatic cycle(input logic w, input logic r, input logic [15:0] a, input logic [8:0] t,
                         input logic [63:0] d, input logic rs);
        logic        nv;
        logic [8:0]  nt;
        logic [63:0] nd;
        int          dc;
        wr = w; rd = r; addr = a; tid = t; wdata = d; rst = rs;
        if (rs) begin
            exp_valid = 1'b0;
            for (int c = 0; c < NCH; c++) begin
                mq[c].delete();
                m_ovf[c] = 1'b0;
                m_unf[c] = 1'b0;
            end
            nv = 1'b0; nt = '0; nd = '0;
        end else begin
            nv = r;
            nt = t;
            nd = r ? model_rd(a) : 64'h0;
            dc = chan_of(a, 16'h0020);
            if (r && dc >= 0) begin
                if (mq[dc].size() > 0) void'(mq[dc].pop_front());
                else m_unf[dc] = 1'b1;
            end
            if (w && dc >= 0) begin
                if (mq[dc].size() < DEP) mq[dc].push_back(d);
                else m_ovf[dc] = 1'b1;
            end
            if (w && a == 16'h0060) begin
                for (int c = 0; c < NCH; c++) begin
                    if (d[c]) begin
                        mq[c].delete();
                        m_ovf[c] = 1'b0;
                        m_unf[c] = 1'b0;
                    end
                end
            end
        end
        @(posedge clk);
        #1;
        exp_valid = nv;
        exp_tid   = nt;
        exp_data  = nd;
        wr = 1'b0; rd = 1'b0; rst = 1'b0;
    endtask

    task automatic wr_op(input logic [15:0] a, input logic [63:0] d);
        cycle(1'b1, 1'b0, a, 9'h0, d, 1'b0);
    endtask

    task automatic rd_lit(input string nm, input logic [15:0] a, input logic [8:0] t,
                          input logic [63:0] req);
        cycle(1'b0, 1'b1, a, t, 64'h0, 1'b0);
        check({nm, "_valid"}, 64'(resp_valid), 64'h1);
        check({nm, "_tid"}, 64'(resp_tid), 64'(t));
        check(nm, resp_data, req);
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            check("resp_valid", 64'(resp_valid), 64'(exp_valid));
            if (exp_valid) begin
                check("resp_tid", 64'(resp_tid), 64'(exp_tid));
                check("resp_data", resp_data, exp_data);
            end
        end
    end

    initial begin
        logic [15:0] a;
        logic [63:0] d;
        logic [63:0] peek_exp;
        logic        w;
        logic        r;
        logic        rs;
        int          sel;
        int          ch;
        logic [15:0] unm [7];
        unm[0] = 16'h0021; unm[1] = 16'h0028; unm[2] = 16'h0048; unm[3] = 16'h0000;
        unm[4] = 16'hffff; unm[5] = 16'h0061; unm[6] = 16'h0088;

        for (int i = 0; i < 3; i++) cycle(1'b0, 1'b0, 16'h0, 9'h0, 64'h0, 1'b1);
        check("reset_valid", 64'(resp_valid), 64'h0);
        check("reset_tid", 64'(resp_tid), 64'h0);
        check("reset_data", resp_data, 64'h0);
        chk_en = 1'b1;

        wr_op(16'h0020, 64'hA5);
        rd_lit("basic_pop", 16'h0020, 9'h11, 64'hA5);
        rd_lit("basic_stat", 16'h0040, 9'h12, 64'h10000);

        for (int i = 1; i <= 17; i++) wr_op(16'h0022, 64'(i));
        rd_lit("ovf_stat", 16'h0042, 9'h1, 64'h60010);
        for (int i = 1; i <= 16; i++) rd_lit("ovf_pop", 16'h0022, 9'h2, 64'(i));
        rd_lit("ovf_stat_empty", 16'h0042, 9'h1, 64'h50000);

        rd_lit("unf_data", 16'h0024, 9'h3, 64'h0);
        rd_lit("unf_stat", 16'h0044, 9'h3, 64'h90000);
        wr_op(16'h0060, 64'h04);
        rd_lit("clr_stat", 16'h0044, 9'h3, 64'h10000);

        wr_op(16'h0020, 64'h1);
        wr_op(16'h0026, 64'h1);
        wr_op(16'h0060, 64'h01);
        rd_lit("indep_stat3", 16'h0046, 9'h4, 64'h1);
        rd_lit("indep_data3", 16'h0026, 9'h4, 64'h1);
        rd_lit("indep_stat0", 16'h0040, 9'h4, 64'h10000);

        wr_op(16'h0060, 64'h02);
        for (int i = 0; i < 16; i++) wr_op(16'h0022, 64'(100 + i));
        cycle(1'b1, 1'b1, 16'h0022, 9'h5, 64'd200, 1'b0);
        check("fullrw_data", resp_data, 64'd100);
        rd_lit("fullrw_stat", 16'h0042, 9'h5, 64'h20010);
        cycle(1'b1, 1'b1, 16'h0024, 9'h6, 64'h77, 1'b0);
        check("emptyrw_data", resp_data, 64'h0);
        rd_lit("emptyrw_stat", 16'h0044, 9'h6, 64'h80001);
        rd_lit("emptyrw_pop", 16'h0024, 9'h6, 64'h77);

        wr_op(16'h0060, 64'hff);
`ifdef MMIO_FIFO_PEEK_EN
        peek_exp = 64'h55;
`else
        peek_exp = 64'h0;
`endif
        wr_op(16'h0020, 64'h55);
        rd_lit("peek_1", 16'h0080, 9'h7, peek_exp);
        rd_lit("peek_2", 16'h0080, 9'h7, peek_exp);
        rd_lit("peek_stat", 16'h0040, 9'h7, 64'h1);
        rd_lit("unmapped_ch4", 16'h0028, 9'h8, 64'h0);
        rd_lit("unmapped_odd", 16'h0021, 9'h8, 64'h0);
        rd_lit("ctrl_read", 16'h0060, 9'h8, 64'h0);

        for (int i = 0; i < 5; i++) wr_op(16'h0022, 64'(i + 1));
        cycle(1'b0, 1'b1, 16'h0042, 9'h9, 64'h0, 1'b0);
        cycle(1'b0, 1'b1, 16'h0042, 9'ha, 64'h0, 1'b1);
        check("rst_no_resp", 64'(resp_valid), 64'h0);
        cycle(1'b0, 1'b0, 16'h0, 9'h0, 64'h0, 1'b0);
        check("rst_no_resp2", 64'(resp_valid), 64'h0);
        rd_lit("rst_stat", 16'h0042, 9'hb, 64'h10000);

        for (int i = 0; i < 3000; i++) begin
            sel = $urandom_range(0, 99);
            ch  = $urandom_range(0, NCH - 1);
            if (sel < 40) a = 16'h0020 + 16'(2 * ch);
            else if (sel < 60) a = 16'h0040 + 16'(2 * ch);
            else if (sel < 66) a = 16'h0060;
            else if (sel < 80) a = 16'h0080 + 16'(2 * ch);
            else a = unm[$urandom_range(0, 6)];
            w = ($urandom_range(0, 99) < 55);
            r = ($urandom_range(0, 99) < 40);
            d = {$urandom, $urandom};
            if (a == 16'h0060 && $urandom_range(0, 3) != 0) d = 64'h0;
            rs = ($urandom_range(0, 299) == 0);
            cycle(w, r, a, 9'($urandom), d, rs);
        end
        cycle(1'b0, 1'b0, 16'h0, 9'h0, 64'h0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
